// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, 8 data bits LSB first, 1 stop bit, ready/valid byte output.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_rx #(
  parameter int SYS_PERIOD = 50000000,
  parameter int BPS        = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_parity_err
);
  localparam int CLKS_PER_BIT = SYS_PERIOD / BPS;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          perr_q, perr_d;
  logic          deliver;

  // rxd_prev_q lags the synchronized line by one cycle for 1->0 edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    perr_d  = 1'b0;
    deliver = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rxd_prev_q && !rxd_s2_q) state_d = START;
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rxd_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rxd_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = PAR_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          par_d   = rxd_s2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          // frame error outranks parity error
          if (!rxd_s2_q)                              ferr_d  = 1'b1;
          else if (PAR_EN && ((^shift_q) ^ par_q))    perr_d  = 1'b1;
          else                                        deliver = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (deliver) begin
      if (valid_q && !rx_ready) ovr_d = 1'b1;
      else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_busy       = (state_q != IDLE);
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;
  assign rx_parity_err = PAR_EN ? perr_q : 1'b0;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud (434 clocks, 8680 ns per bit).
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BIT = 8680;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err;

  int total = 0;
  int bad   = 0;

  // monitor counters, only ever incremented; tests work on differences
  int         n_del = 0, n_vcyc = 0, n_ovr = 0, n_ferr = 0, n_perr = 0, n_busy = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_v = 1'b0;

  uart_rx dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    prev_v <= rx_valid;
    if (rx_valid && !prev_v) begin
      n_del     <= n_del + 1;
      last_data <= rx_data;
    end
    if (rx_valid)      n_vcyc <= n_vcyc + 1;
    if (rx_overrun)    n_ovr  <= n_ovr + 1;
    if (rx_frame_err)  n_ferr <= n_ferr + 1;
    if (rx_parity_err) n_perr <= n_perr + 1;
    if (rx_busy)       n_busy <= n_busy + 1;
  end

  // start, 8 data LSB first, optional parity, stop, one idle bit
  task automatic send_byte(input logic [7:0] d, input logic stop, input logic flip_par);
    uart_rxd = 1'b0; #(BIT);
    for (int i = 0; i < 8; i++) begin uart_rxd = d[i]; #(BIT); end
    if (PAR_EN) begin uart_rxd = (^d) ^ flip_par; #(BIT); end
    uart_rxd = stop; #(BIT);
    uart_rxd = 1'b1; #(BIT);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", rx_busy); end
    total++; if ({rx_frame_err, rx_overrun, rx_parity_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {rx_frame_err, rx_overrun, rx_parity_err}); end
    rst = 1'b0;
    #(2*BIT);
  endtask

  task automatic test_basic;
    int d0, v0, f0, o0, p0;
    rx_ready = 1'b1;
    d0 = n_del; v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
    send_byte(8'h41, 1'b1, 1'b0);
    total++; if (n_del - d0 != 1) begin bad++; $display("FAIL basic_deliveries got=%0d want=1", n_del - d0); end
    total++; if (last_data !== 8'h41) begin bad++; $display("FAIL basic_data got=%h want=41", last_data); end
    total++; if (n_vcyc - v0 != 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d want=1", n_vcyc - v0); end
    total++; if ((n_ferr - f0) + (n_ovr - o0) + (n_perr - p0) != 0) begin
      bad++; $display("FAIL basic_flags got=%0d want=0", (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0)); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", rx_busy); end
  endtask

  task automatic test_overrun;
    int d0, o0;
    rx_ready = 1'b0;
    d0 = n_del; o0 = n_ovr;
    send_byte(8'h41, 1'b1, 1'b0);
    #(5*BIT);
    send_byte(8'h0F, 1'b1, 1'b0);
    #1;
    total++; if (rx_data !== 8'h41) begin bad++; $display("FAIL ovr_data got=%h want=41", rx_data); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", rx_valid); end
    total++; if (n_ovr - o0 != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", n_ovr - o0); end
    total++; if (n_del - d0 != 1) begin bad++; $display("FAIL ovr_deliveries got=%0d want=1", n_del - d0); end
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain_valid got=%b want=0", rx_valid); end
  endtask

  task automatic test_glitch;
    int d0, b0;
    d0 = n_del; b0 = n_busy;
    uart_rxd = 1'b0; #3000;
    uart_rxd = 1'b1; #(2*BIT);
    total++; if (n_busy - b0 < 210 || n_busy - b0 > 225) begin
      bad++; $display("FAIL glitch_busy_cycles got=%0d want=217", n_busy - b0); end
    total++; if (n_del - d0 != 0 || rx_valid !== 1'b0) begin
      bad++; $display("FAIL glitch_valid got=%0d/%b want=0/0", n_del - d0, rx_valid); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", rx_busy); end
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = n_del; f0 = n_ferr;
    send_byte(8'h55, 1'b0, 1'b0);
    total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", n_ferr - f0); end
    total++; if (n_del - d0 != 0) begin bad++; $display("FAIL ferr_deliveries got=%0d want=0", n_del - d0); end
    send_byte(8'hA5, 1'b1, 1'b0);
    total++; if (n_del - d0 != 1 || last_data !== 8'hA5) begin
      bad++; $display("FAIL ferr_next got=%0d/%h want=1/a5", n_del - d0, last_data); end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = n_del;
    fork
      send_byte(8'h0F, 1'b1, 1'b0);
      begin
        #(4*BIT + BIT/2);
        rst = 1'b1;
        #1000;
        total++; if ({rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err} !== 13'h0) begin
          bad++; $display("FAIL midrst_outputs got=%h/%b%b%b%b%b want=0", rx_data, rx_valid, rx_busy,
                          rx_frame_err, rx_overrun, rx_parity_err); end
      end
    join
    rst = 1'b0;
    #(BIT);
    send_byte(8'h3C, 1'b1, 1'b0);
    total++; if (n_del - d0 != 1 || last_data !== 8'h3C) begin
      bad++; $display("FAIL midrst_next got=%0d/%h want=1/3c", n_del - d0, last_data); end
  endtask

  task automatic test_parity;
    int d0, p0;
    d0 = n_del; p0 = n_perr;
    if (PAR_EN) begin
      send_byte(8'h07, 1'b1, 1'b1);
      total++; if (n_perr - p0 != 1 || n_del - d0 != 0) begin
        bad++; $display("FAIL par_bad got=%0d/%0d want=1/0", n_perr - p0, n_del - d0); end
      send_byte(8'h07, 1'b1, 1'b0);
      total++; if (n_del - d0 != 1 || last_data !== 8'h07) begin
        bad++; $display("FAIL par_good got=%0d/%h want=1/07", n_del - d0, last_data); end
    end else begin
      total++; if (n_perr != 0) begin bad++; $display("FAIL par_tied got=%0d want=0", n_perr); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
